fwd_bypass_net: RTL and testbench
=================================

Name: fwd_bypass_net

Overview:
- Parametrised second-generation forwarding unit between the RS and EX1 stages.
- Resolves every source operand of every issuing lane from one of these, in priority order:
  - the PRF read port
  - the EX1 result bus
  - the EX2 result bus
  - the CMT (CDB) bus
  - a HIST_DEPTH-deep history of past CMT results, which covers the CMT-to-PRF write/read gap
- Registers the resolved operands into the EX1 pipeline register, with stall-hold.
- Flags and counts operands that match no source, so the RS can replay them.

Parameters:
- NUM_LANES, 4, issue lanes.
- NUM_SRCS, 2, source operands per lane.
- CDB_LANES, 4, entries per result bus (EX1, EX2, CMT each).
- ROBID_W, 6, ROB tag width.
- DATA_W, 32, operand width.
- CTRL_W, 8, opaque per-lane control payload (alu_ctrl/func3 packed).
- HIST_DEPTH, 2, CMT history stages; legal range 1..4.
- CNT_W, 16, replay counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fwd_v  in  NUM_LANES  lane valid in FWD stage
- fwd_robid  in  NUM_LANES*ROBID_W  destination tag
- fwd_ctrl  in  NUM_LANES*CTRL_W  control payload
- fwd_src_tag  in  NUM_LANES*NUM_SRCS*ROBID_W  source producer tag
- fwd_src_prf  in  NUM_LANES*NUM_SRCS  1 = operand already in PRF
- prf_rdata  in  NUM_LANES*NUM_SRCS*DATA_W  PRF read data, port index = lane*NUM_SRCS+src
- ex1_res_v / ex1_res_robid / ex1_res_data  in  CDB_LANES * (1 / ROBID_W / DATA_W)  EX1 result bus
- ex2_res_v / ex2_res_robid / ex2_res_data  in  same widths  EX2 result bus
- cmt_v / cmt_robid / cmt_data  in  same widths  CDB commit bus
- stall  in  1  EX1 not accepting
- ex1_v  out  NUM_LANES  registered lane valid
- ex1_robid  out  NUM_LANES*ROBID_W
- ex1_ctrl  out  NUM_LANES*CTRL_W
- ex1_src_data  out  NUM_LANES*NUM_SRCS*DATA_W
- replay  out  NUM_LANES  registered: lane dropped, an operand was unresolved
- replay_cnt  out  CNT_W  saturating count of replayed lanes

Behaviour:
- Reset (async, rst_n=0): ex1_v, replay, ex1_robid, ex1_ctrl, ex1_src_data, replay_cnt, all history valids and data are 0. Outputs are 0 while reset is asserted, including when reset arrives mid-stall.
- Operand select (combinational, per lane/src):
  - src_prf=1: prf_rdata.
  - Otherwise, first match in this order: EX1 bus, EX2 bus, CMT bus, hist[0] (newest) .. hist[HIST_DEPTH-1].
  - Match = entry valid and robid equal.
  - Within one bus/stage, the lowest CDB index wins.
  - Tag 0 is an ordinary tag.
- Unresolved: fwd_v=1, src_prf=0 and no match on any source. The lane is unresolved if any of its sources is.
- History shift, every cycle independent of stall: hist[0] <= CMT bus (v/robid/data per entry); hist[k] <= hist[k-1]. An entry leaves after HIST_DEPTH cycles.
- Pipeline register, latency 1:
  - When stall=0, each lane loads:
    - ex1_v = fwd_v & ~unresolved
    - replay = fwd_v & unresolved
    - robid, ctrl, src_data
    - src_data of an unresolved operand is 0
  - When stall=1, ex1_* and replay hold their values. FWD inputs are ignored; the RS holds them.
- replay_cnt:
  - When stall=0, adds the popcount of the next replay vector.
  - Saturates at 2^CNT_W-1 and never wraps.
- fwd_v=0 lanes: ex1_v=0 and replay=0. Payload is still loaded (don't-care).
- Same tag on several buses: the youngest stage wins (EX1 over EX2 over CMT over history), per the order above.

Test Plan:
- Lane0 src0 prf=1, prf_rdata[0]=0x11; src1 tag 5, ex1_res entry2 {v,5,0xAA} -> next cycle ex1_v[0]=1, ex1_src_data = {0x11, 0xAA}, replay=0.
- Tag 9 present on EX2 entry0 (0x22) and CMT entry1 (0x33) -> operand 0x22. Tag 9 on EX1 entries 1 and 3 (0x44, 0x55) -> operand 0x44.
- CMT {v,7,0x77} at cycle t, nothing afterwards. Lane1 src0 tag 7, prf=0, issued at t+1 -> 0x77 (hist[0]). Issued at t+HIST_DEPTH -> 0x77 (hist[HIST_DEPTH-1]). Issued at t+HIST_DEPTH+1 -> ex1_v[1]=0, replay[1]=1, replay_cnt increments by 1.
- All 4 lanes unresolved with stall=0 -> replay=4'hF, replay_cnt +4. Hold stall=1 for 3 cycles while changing inputs -> ex1_* and replay unchanged, replay_cnt unchanged.
- Preload replay_cnt to 0xFFFE, then replay 2 lanes -> replay_cnt=0xFFFF, and it stays there on later replays.
- Assert rst_n=0 asynchronously mid-stall with ex1_v=4'hF -> all outputs 0 immediately. First post-reset cycle with CMT tag 3 and no new CMT afterwards -> history hits after reset only for the new entry.

Source files
------------

// File: rtl/fwd_bypass_net.sv
// Operand forwarding between RS and EX1: picks each source operand from the PRF,
// the EX1/EX2/CMT result buses or a short CMT history, then registers it into EX1.
module fwd_bypass_net #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_SRCS   = 2,
  parameter int CDB_LANES  = 4,
  parameter int ROBID_W    = 6,
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int HIST_DEPTH = 2,  // legal range 1..4
  parameter int CNT_W      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_LANES-1:0]                   fwd_v,
  input  logic [NUM_LANES*ROBID_W-1:0]           fwd_robid,
  input  logic [NUM_LANES*CTRL_W-1:0]            fwd_ctrl,
  input  logic [NUM_LANES*NUM_SRCS*ROBID_W-1:0]  fwd_src_tag,
  input  logic [NUM_LANES*NUM_SRCS-1:0]          fwd_src_prf,
  input  logic [NUM_LANES*NUM_SRCS*DATA_W-1:0]   prf_rdata,
  input  logic [CDB_LANES-1:0]                   ex1_res_v,
  input  logic [CDB_LANES*ROBID_W-1:0]           ex1_res_robid,
  input  logic [CDB_LANES*DATA_W-1:0]            ex1_res_data,
  input  logic [CDB_LANES-1:0]                   ex2_res_v,
  input  logic [CDB_LANES*ROBID_W-1:0]           ex2_res_robid,
  input  logic [CDB_LANES*DATA_W-1:0]            ex2_res_data,
  input  logic [CDB_LANES-1:0]                   cmt_v,
  input  logic [CDB_LANES*ROBID_W-1:0]           cmt_robid,
  input  logic [CDB_LANES*DATA_W-1:0]            cmt_data,
  input  logic                                   stall,
  output logic [NUM_LANES-1:0]                   ex1_v,
  output logic [NUM_LANES*ROBID_W-1:0]           ex1_robid,
  output logic [NUM_LANES*CTRL_W-1:0]            ex1_ctrl,
  output logic [NUM_LANES*NUM_SRCS*DATA_W-1:0]   ex1_src_data,
  output logic [NUM_LANES-1:0]                   replay,
  output logic [CNT_W-1:0]                       replay_cnt
);

  localparam int NOPS = NUM_LANES * NUM_SRCS;

  logic [HIST_DEPTH-1:0][CDB_LANES-1:0]         hist_v_q;
  logic [HIST_DEPTH-1:0][CDB_LANES*ROBID_W-1:0] hist_robid_q;
  logic [HIST_DEPTH-1:0][CDB_LANES*DATA_W-1:0]  hist_data_q;

  logic [NOPS-1:0]                  op_hit;
  logic [NOPS*DATA_W-1:0]           op_data;
  logic [NUM_LANES-1:0]             lane_unres;
  logic [NUM_LANES-1:0]             ex1_v_d, ex1_v_q;
  logic [NUM_LANES-1:0]             replay_d, replay_q;
  logic [NUM_LANES*ROBID_W-1:0]     ex1_robid_q;
  logic [NUM_LANES*CTRL_W-1:0]      ex1_ctrl_q;
  logic [NOPS*DATA_W-1:0]           ex1_src_data_q;
  logic [CNT_W-1:0]                 cnt_d, cnt_q;
  logic [CNT_W:0]                   pop, cnt_sum;

  // Returns {hit, data}; scanning high to low leaves the lowest matching index.
  function automatic logic [DATA_W:0] bus_lookup(
    input logic [CDB_LANES-1:0]         v,
    input logic [CDB_LANES*ROBID_W-1:0] tags,
    input logic [CDB_LANES*DATA_W-1:0]  data,
    input logic [ROBID_W-1:0]           tag
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int i = CDB_LANES - 1; i >= 0; i--) begin
      if (v[i] && (tags[i*ROBID_W +: ROBID_W] == tag)) begin
        r = {1'b1, data[i*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  // The history bridges the cycles between a CMT broadcast and its PRF readability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v_q     <= '0;
      hist_robid_q <= '0;
      hist_data_q  <= '0;
    end else begin
      hist_v_q[0]     <= cmt_v;
      hist_robid_q[0] <= cmt_robid;
      hist_data_q[0]  <= cmt_data;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_v_q[k]     <= hist_v_q[k-1];
        hist_robid_q[k] <= hist_robid_q[k-1];
        hist_data_q[k]  <= hist_data_q[k-1];
      end
    end
  end

  // Oldest source first so each younger hit overrides; PRF overrides everything.
  always_comb begin
    logic [DATA_W:0]  res;
    logic [DATA_W:0]  cand;
    logic [ROBID_W-1:0] tag;
    op_hit  = '0;
    op_data = '0;
    for (int op = 0; op < NOPS; op++) begin
      tag = fwd_src_tag[op*ROBID_W +: ROBID_W];
      res = '0;
      for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
        cand = bus_lookup(hist_v_q[k], hist_robid_q[k], hist_data_q[k], tag);
        if (cand[DATA_W]) res = cand;
      end
      cand = bus_lookup(cmt_v, cmt_robid, cmt_data, tag);
      if (cand[DATA_W]) res = cand;
      cand = bus_lookup(ex2_res_v, ex2_res_robid, ex2_res_data, tag);
      if (cand[DATA_W]) res = cand;
      cand = bus_lookup(ex1_res_v, ex1_res_robid, ex1_res_data, tag);
      if (cand[DATA_W]) res = cand;
      if (fwd_src_prf[op]) res = {1'b1, prf_rdata[op*DATA_W +: DATA_W]};
      op_hit[op]                    = res[DATA_W];
      op_data[op*DATA_W +: DATA_W]  = res[DATA_W-1:0];
    end
  end

  always_comb begin
    lane_unres = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        if (!op_hit[l*NUM_SRCS+s]) lane_unres[l] = 1'b1;
      end
    end
    ex1_v_d  = fwd_v & ~lane_unres;
    replay_d = fwd_v & lane_unres;
  end

  always_comb begin
    pop = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      pop = pop + {{CNT_W{1'b0}}, replay_d[l]};
    end
    cnt_sum = {1'b0, cnt_q} + pop;
    cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex1_v_q        <= '0;
      replay_q       <= '0;
      ex1_robid_q    <= '0;
      ex1_ctrl_q     <= '0;
      ex1_src_data_q <= '0;
      cnt_q          <= '0;
    end else if (!stall) begin
      ex1_v_q        <= ex1_v_d;
      replay_q       <= replay_d;
      ex1_robid_q    <= fwd_robid;
      ex1_ctrl_q     <= fwd_ctrl;
      ex1_src_data_q <= op_data;
      cnt_q          <= cnt_d;
    end
  end

  assign ex1_v        = ex1_v_q;
  assign replay       = replay_q;
  assign ex1_robid    = ex1_robid_q;
  assign ex1_ctrl     = ex1_ctrl_q;
  assign ex1_src_data = ex1_src_data_q;
  assign replay_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed scoreboard bench for fwd_bypass_net: the driver queues hand-computed
// EX1 register contents, a monitor pops and compares one entry per clock.
module tb_fwd_bypass_net;
  localparam int NL = 4, NS = 2, CL = 4, RW = 6, DW = 32, CW = 8, HD = 2, CNW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NL-1:0]       fwd_v;
  logic [NL*RW-1:0]    fwd_robid;
  logic [NL*CW-1:0]    fwd_ctrl;
  logic [NL*NS*RW-1:0] fwd_src_tag;
  logic [NL*NS-1:0]    fwd_src_prf;
  logic [NL*NS*DW-1:0] prf_rdata;
  logic [CL-1:0]       ex1_res_v, ex2_res_v, cmt_v;
  logic [CL*RW-1:0]    ex1_res_robid, ex2_res_robid, cmt_robid;
  logic [CL*DW-1:0]    ex1_res_data, ex2_res_data, cmt_data;
  logic                stall;
  logic [NL-1:0]       ex1_v, replay;
  logic [NL*RW-1:0]    ex1_robid;
  logic [NL*CW-1:0]    ex1_ctrl;
  logic [NL*NS*DW-1:0] ex1_src_data;
  logic [CNW-1:0]      replay_cnt;

  fwd_bypass_net #(
    .NUM_LANES(NL), .NUM_SRCS(NS), .CDB_LANES(CL), .ROBID_W(RW),
    .DATA_W(DW), .CTRL_W(CW), .HIST_DEPTH(HD), .CNT_W(CNW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fwd_v(fwd_v), .fwd_robid(fwd_robid), .fwd_ctrl(fwd_ctrl),
    .fwd_src_tag(fwd_src_tag), .fwd_src_prf(fwd_src_prf), .prf_rdata(prf_rdata),
    .ex1_res_v(ex1_res_v), .ex1_res_robid(ex1_res_robid), .ex1_res_data(ex1_res_data),
    .ex2_res_v(ex2_res_v), .ex2_res_robid(ex2_res_robid), .ex2_res_data(ex2_res_data),
    .cmt_v(cmt_v), .cmt_robid(cmt_robid), .cmt_data(cmt_data),
    .stall(stall),
    .ex1_v(ex1_v), .ex1_robid(ex1_robid), .ex1_ctrl(ex1_ctrl),
    .ex1_src_data(ex1_src_data), .replay(replay), .replay_cnt(replay_cnt)
  );

  typedef struct {
    logic [NL-1:0]       v;
    logic [NL-1:0]       rp;
    logic [NL-1:0]       mask;
    logic [NL*RW-1:0]    robid;
    logic [NL*CW-1:0]    ctrl;
    logic [NL*NS*DW-1:0] data;
    logic [CNW-1:0]      cnt;
  } exp_t;

  exp_t q[$];
  exp_t cur, last;
  int   checks = 0;
  int   passes = 0;
  int   seq = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex1_v", 256'(ex1_v), 256'(e.v));
      chk("replay", 256'(replay), 256'(e.rp));
      chk("replay_cnt", 256'(replay_cnt), 256'(e.cnt));
      for (int l = 0; l < NL; l++) begin
        if (e.mask[l]) begin
          chk("ex1_robid", 256'(ex1_robid[l*RW +: RW]), 256'(e.robid[l*RW +: RW]));
          chk("ex1_ctrl", 256'(ex1_ctrl[l*CW +: CW]), 256'(e.ctrl[l*CW +: CW]));
          chk("ex1_src_data", 256'(ex1_src_data[l*NS*DW +: NS*DW]),
              256'(e.data[l*NS*DW +: NS*DW]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

  task automatic clr();
    fwd_v = '0; fwd_src_prf = '0; fwd_src_tag = '0; prf_rdata = '0;
    ex1_res_v = '0; ex1_res_robid = '0; ex1_res_data = '0;
    ex2_res_v = '0; ex2_res_robid = '0; ex2_res_data = '0;
    cmt_v = '0; cmt_robid = '0; cmt_data = '0;
    stall = 1'b0;
    for (int l = 0; l < NL; l++) begin
      fwd_robid[l*RW +: RW] = RW'(seq * 4 + l);
      fwd_ctrl[l*CW +: CW]  = CW'(8'hA0 + seq + l * 16);
    end
    cur.v = '0; cur.rp = '0; cur.mask = '0; cur.data = '0; cur.cnt = '0;
    cur.robid = fwd_robid;
    cur.ctrl  = fwd_ctrl;
  endtask

  task automatic src(input int l, input int s, input logic prf, input logic [RW-1:0] tag,
                     input logic [DW-1:0] pd, input logic [DW-1:0] ed);
    int idx;
    idx = l * NS + s;
    fwd_v[l] = 1'b1;
    cur.mask[l] = 1'b1;
    fwd_src_prf[idx] = prf;
    fwd_src_tag[idx*RW +: RW] = tag;
    prf_rdata[idx*DW +: DW] = pd;
    cur.data[idx*DW +: DW] = ed;
  endtask

  task automatic bus(input int b, input int i, input logic v, input logic [RW-1:0] tag,
                     input logic [DW-1:0] d);
    case (b)
      0: begin ex1_res_v[i] = v; ex1_res_robid[i*RW +: RW] = tag; ex1_res_data[i*DW +: DW] = d; end
      1: begin ex2_res_v[i] = v; ex2_res_robid[i*RW +: RW] = tag; ex2_res_data[i*DW +: DW] = d; end
      default: begin cmt_v[i] = v; cmt_robid[i*RW +: RW] = tag; cmt_data[i*DW +: DW] = d; end
    endcase
  endtask

  task automatic lane_exp(input logic [NL-1:0] v, input logic [NL-1:0] rp);
    cur.v = v; cur.rp = rp;
  endtask

  // Push what EX1 must hold after the coming edge, then move to the next drive point.
  task automatic step();
    logic [CNW:0] s;
    if (stall) begin
      q.push_back(last);
    end else begin
      s = {1'b0, last.cnt} + (CNW+1)'($countones(cur.rp));
      cur.cnt = s[CNW] ? {CNW{1'b1}} : s[CNW-1:0];
      last = cur;
      q.push_back(cur);
    end
    seq++;
    @(negedge clk);
  endtask

  task automatic unres(input int n);
    logic [NL-1:0] m;
    clr();
    m = '0;
    for (int l = 0; l < n; l++) begin
      src(l, 0, 1'b0, 6'h3F, 32'h0, 32'h0);
      m[l] = 1'b1;
    end
    lane_exp('0, m);
    step();
  endtask

  task automatic chk_all_zero(input string tagname);
    chk({tagname, "_ex1_v"}, 256'(ex1_v), 256'(0));
    chk({tagname, "_replay"}, 256'(replay), 256'(0));
    chk({tagname, "_robid"}, 256'(ex1_robid), 256'(0));
    chk({tagname, "_ctrl"}, 256'(ex1_ctrl), 256'(0));
    chk({tagname, "_data"}, 256'(ex1_src_data), 256'(0));
    chk({tagname, "_cnt"}, 256'(replay_cnt), 256'(0));
  endtask

  initial begin
    int r;
    last = '{default: '0};
    clr();
    #2 rst_n = 1'b0;
    #10 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // PRF operand plus EX1 bus entry 2 (EX2 carries a stale copy of the same tag)
    clr();
    src(0, 0, 1'b1, 6'd0, 32'h11, 32'h11);
    src(0, 1, 1'b0, 6'd5, 32'h0, 32'hAA);
    bus(0, 2, 1'b1, 6'd5, 32'hAA);
    bus(1, 0, 1'b1, 6'd5, 32'hBB);
    lane_exp(4'b0001, 4'b0000);
    step();

    // EX2 beats CMT; invalid EX1 entry ignored; tag 0 resolves from CMT entry 3
    clr();
    bus(0, 0, 1'b0, 6'd9, 32'hDEAD);
    bus(1, 0, 1'b1, 6'd9, 32'h22);
    bus(2, 1, 1'b1, 6'd9, 32'h33);
    bus(2, 3, 1'b1, 6'd0, 32'h5A);
    src(0, 0, 1'b0, 6'd9, 32'h0, 32'h22);
    src(0, 1, 1'b1, 6'd0, 32'h01, 32'h01);
    src(3, 0, 1'b0, 6'd0, 32'h0, 32'h5A);
    src(3, 1, 1'b0, 6'd0, 32'h0, 32'h5A);
    lane_exp(4'b1001, 4'b0000);
    step();

    // EX1 lowest index wins over EX2; lane1 tag 0 from hist[0]
    clr();
    bus(0, 1, 1'b1, 6'd9, 32'h44);
    bus(0, 3, 1'b1, 6'd9, 32'h55);
    bus(1, 0, 1'b1, 6'd9, 32'h22);
    src(0, 0, 1'b0, 6'd9, 32'h0, 32'h44);
    src(0, 1, 1'b1, 6'd0, 32'h02, 32'h02);
    src(1, 0, 1'b0, 6'd0, 32'h0, 32'h5A);
    src(1, 1, 1'b1, 6'd0, 32'h07, 32'h07);
    src(2, 0, 1'b0, 6'd9, 32'h0, 32'h44);
    src(2, 1, 1'b1, 6'd0, 32'h03, 32'h03);
    lane_exp(4'b0111, 4'b0000);
    step();

    clr(); lane_exp('0, '0); step();
    clr(); lane_exp('0, '0); step();

    // History ageing of CMT tag 7
    clr();
    bus(2, 2, 1'b1, 6'd7, 32'h77);
    lane_exp('0, '0);
    step();
    for (int d = 1; d <= HD; d++) begin
      clr();
      src(1, 0, 1'b0, 6'd7, 32'h0, 32'h77);
      src(1, 1, 1'b1, 6'd0, 32'h101, 32'h101);
      lane_exp(4'b0010, 4'b0000);
      step();
    end
    clr();
    src(1, 0, 1'b0, 6'd7, 32'h0, 32'h0);
    src(1, 1, 1'b1, 6'd0, 32'h101, 32'h101);
    lane_exp(4'b0000, 4'b0010);
    step();

    // All four lanes unresolved, then hold under stall with changing inputs
    clr();
    for (int l = 0; l < NL; l++) begin
      src(l, 0, 1'b0, 6'h3F, 32'h0, 32'h0);
      src(l, 1, 1'b1, 6'd0, 32'h1000 + l, 32'h1000 + l);
    end
    lane_exp(4'b0000, 4'b1111);
    step();
    for (int k = 0; k < 3; k++) begin
      clr();
      stall = 1'b1;
      for (int l = 0; l < NL; l++) src(l, 0, 1'b1, 6'd0, 32'h900 + k, 32'h900 + k);
      src(0, 1, 1'b0, 6'h3F, 32'h0, 32'h9);
      bus(0, 0, 1'b1, 6'h3F, 32'h9);
      step();
    end

    // Drive the counter up to 0xFFFE, then saturate
    while (last.cnt <= 16'hFFFA) unres(4);
    r = int'(16'hFFFE - last.cnt);
    if (r > 0) unres(r);
    chk("cnt_preload", 256'(replay_cnt), 256'(16'hFFFE));
    unres(2);
    chk("cnt_sat", 256'(replay_cnt), 256'(16'hFFFF));
    unres(4);
    unres(1);
    chk("cnt_stays", 256'(replay_cnt), 256'(16'hFFFF));

    // Fill EX1, stall with a CMT entry entering history, then reset mid-stall
    clr();
    for (int l = 0; l < NL; l++) begin
      src(l, 0, 1'b1, 6'd0, 32'h2000 + l, 32'h2000 + l);
      src(l, 1, 1'b1, 6'd0, 32'h3000 + l, 32'h3000 + l);
    end
    lane_exp(4'b1111, 4'b0000);
    step();
    clr();
    stall = 1'b1;
    bus(2, 0, 1'b1, 6'd4, 32'h444);
    step();
    clr();
    stall = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    #2 chk_all_zero("rst_held");
    @(negedge clk);
    last = '{default: '0};

    // Only the post-reset CMT tag 3 may hit; pre-reset tag 4 must be gone
    clr();
    rst_n = 1'b1;
    bus(2, 1, 1'b1, 6'd3, 32'h333);
    src(0, 0, 1'b0, 6'd4, 32'h0, 32'h0);
    src(0, 1, 1'b1, 6'd0, 32'h1, 32'h1);
    src(1, 0, 1'b0, 6'd3, 32'h0, 32'h333);
    src(1, 1, 1'b1, 6'd0, 32'h2, 32'h2);
    lane_exp(4'b0010, 4'b0001);
    step();
    clr();
    src(0, 0, 1'b0, 6'd3, 32'h0, 32'h333);
    src(0, 1, 1'b1, 6'd0, 32'h1, 32'h1);
    src(1, 0, 1'b0, 6'd4, 32'h0, 32'h0);
    src(1, 1, 1'b1, 6'd0, 32'h2, 32'h2);
    lane_exp(4'b0001, 4'b0010);
    step();
    clr();
    src(0, 0, 1'b0, 6'd3, 32'h0, 32'h333);
    src(0, 1, 1'b1, 6'd0, 32'h5, 32'h5);
    lane_exp(4'b0001, 4'b0000);
    step();
    clr();
    src(0, 0, 1'b0, 6'd3, 32'h0, 32'h0);
    src(0, 1, 1'b1, 6'd0, 32'h5, 32'h5);
    lane_exp(4'b0000, 4'b0001);
    step();

    clr();
    lane_exp('0, '0);
    step();
    repeat (2) @(negedge clk);
    chk("queue_drained", 256'(q.size()), 256'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
